// File: rtl/bypass_fader_if.sv
// Sample-path bundle for bypass_fader: effect select, fade rate, dry/wet samples in,
// crossfaded sample and fade-in-progress flag out.
interface bypass_fader_if #(
    parameter int WIDTH = 24
);
    logic             Enable;
    logic [7:0]       Fade_Len;
    logic [WIDTH-1:0] Dry_In;
    logic [WIDTH-1:0] Wet_In;
    logic [WIDTH-1:0] D_Out;
    logic             Busy;

    modport master (output Enable, Fade_Len, Dry_In, Wet_In, input D_Out, Busy);
    modport slave  (input Enable, Fade_Len, Dry_In, Wet_In, output D_Out, Busy);
endinterface

// File: rtl/bypass_fader.sv
// Click-free bypass: linear crossfade between dry and tremolo samples, one gain step
// every Fade_Len+1 Lrck edges. Define BYPASS_FADER_ROUND_EN for round-half-up mixing.
module bypass_fader #(
    parameter int WIDTH = 24
) (
    input  logic          Lrck,
    input  logic          Reset,
    bypass_fader_if.slave bus
);
    localparam int AW = WIDTH + 10;

    typedef enum logic [1:0] {BYPASS, FADE_IN, ACTIVE, FADE_OUT} state_e;

    state_e           state_q, state_d;
    logic [8:0]       g_q, g_d;
    logic [7:0]       h_q, h_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             step;

    logic signed [AW-1:0] wet_x, dry_x, g_x, gi_x, mix;

    always_ff @(posedge Lrck) begin
        if (Reset) begin
            state_q <= BYPASS;
            g_q     <= '0;
            h_q     <= '0;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            h_q     <= h_d;
            d_out_q <= d_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        h_d     = h_q;
        step    = (h_q >= bus.Fade_Len);
        unique case (state_q)
            BYPASS: begin
                if (bus.Enable) begin
                    state_d = FADE_IN;
                    h_d     = '0;
                end
            end
            FADE_IN: begin
                if (!bus.Enable) begin
                    state_d = FADE_OUT;
                    h_d     = '0;
                end else if (g_q == 9'd256) begin
                    // reversed out of a fade-out before its first step: already at full wet
                    state_d = ACTIVE;
                end else if (step) begin
                    g_d = g_q + 9'd1;
                    h_d = '0;
                    if (g_q == 9'd255) state_d = ACTIVE;
                end else begin
                    h_d = h_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (!bus.Enable) begin
                    state_d = FADE_OUT;
                    h_d     = '0;
                end
            end
            FADE_OUT: begin
                if (bus.Enable) begin
                    state_d = FADE_IN;
                    h_d     = '0;
                end else if (g_q == 9'd0) begin
                    state_d = BYPASS;
                end else if (step) begin
                    g_d = g_q - 9'd1;
                    h_d = '0;
                    if (g_q == 9'd1) state_d = BYPASS;
                end else begin
                    h_d = h_q + 8'd1;
                end
            end
            default: state_d = BYPASS;
        endcase
    end

    // Convex mix of two WIDTH-bit samples stays within WIDTH bits after the shift.
    always_comb begin
        wet_x = AW'($signed(bus.Wet_In));
        dry_x = AW'($signed(bus.Dry_In));
        g_x   = AW'({1'b0, g_q});
        gi_x  = AW'(10'd256 - {1'b0, g_q});
`ifdef BYPASS_FADER_ROUND_EN
        mix   = wet_x * g_x + dry_x * gi_x + AW'(128);
`else
        mix   = wet_x * g_x + dry_x * gi_x;
`endif
        d_out_d = WIDTH'(mix >>> 8);
    end

    assign bus.D_Out = d_out_q;
    assign bus.Busy  = (state_q == FADE_IN) || (state_q == FADE_OUT);
endmodule

// File: tb/tb_bypass_fader.sv
// Directed bench for bypass_fader; with Dry_In=0 and Wet_In=256 the output equals the
// pre-edge gain, which is how the gain trajectory is observed.
module tb_bypass_fader;
    logic lrck;
    logic rst;
    int   tests;
    int   fails;
    int   n;
    logic signed [23:0] prev, cur;

    bypass_fader_if #(.WIDTH(24)) bus ();

    bypass_fader #(.WIDTH(24)) dut (
        .Lrck  (lrck),
        .Reset (rst),
        .bus   (bus)
    );

    initial lrck = 1'b0;
    always #5 lrck = ~lrck;

    task automatic tick;
        @(posedge lrck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst          = 1'b1;
        bus.Enable   = 1'b0;
        bus.Fade_Len = 8'd0;
        bus.Dry_In   = 24'd0;
        bus.Wet_In   = 24'd256;
        tick;
        tick;
        chk("rst_dout", bus.D_Out, 0);
        chk("rst_busy", bus.Busy, 0);

        // full fade-in at Fade_Len=0
        rst        = 1'b0;
        bus.Enable = 1'b1;
        tick;
        chk("entry_busy", bus.Busy, 1);
        chk("entry_dout", bus.D_Out, 0);
        n = 0;
        while (bus.Busy === 1'b1 && n < 400) begin
            n++;
            tick;
        end
        chk("fl0_busy_edges", n, 256);
        chk("fl0_last_g", bus.D_Out, 255);
        tick;
        chk("active_g256", bus.D_Out, 256);
        chk("active_busy", bus.Busy, 0);

        bus.Wet_In = 24'd12345;
        tick;
        chk("track_pos", bus.D_Out, 24'd12345);
        bus.Wet_In = 24'hFFFFFB;
        tick;
        chk("track_neg", bus.D_Out, 24'hFFFFFB);
        bus.Wet_In = 24'd256;
        tick;

        // fade out to G=128, then freeze gain with Fade_Len=255
        bus.Enable = 1'b0;
        tick;
        chk("fo_entry_busy", bus.Busy, 1);
        for (int k = 0; k < 128; k++) tick;
        bus.Fade_Len = 8'd255;
        tick;
        chk("g128", bus.D_Out, 128);
        bus.Dry_In = 24'h100000;
        bus.Wet_In = 24'h300000;
        tick;
        chk("mix_half", bus.D_Out, 24'h200000);
        bus.Dry_In = 24'h000001;
        bus.Wet_In = 24'h000000;
        tick;
`ifdef BYPASS_FADER_ROUND_EN
        chk("round_pos", bus.D_Out, 24'h000001);
`else
        chk("round_pos", bus.D_Out, 24'h000000);
`endif
        bus.Dry_In = 24'hFFFFFF;
        tick;
`ifdef BYPASS_FADER_ROUND_EN
        chk("round_neg", bus.D_Out, 24'h000000);
`else
        chk("round_neg", bus.D_Out, 24'hFFFFFF);
`endif
        bus.Dry_In = 24'h800000;
        bus.Wet_In = 24'h7FFFFF;
        tick;
`ifdef BYPASS_FADER_ROUND_EN
        chk("extremes_mid", bus.D_Out, 24'h000000);
`else
        chk("extremes_mid", bus.D_Out, 24'hFFFFFF);
`endif

        // lowering Fade_Len below H resumes stepping; reset at G=77
        bus.Fade_Len = 8'd0;
        bus.Dry_In   = 24'd0;
        bus.Wet_In   = 24'd256;
        n = 0;
        do begin
            tick;
            n++;
        end while (bus.D_Out !== 24'd78 && n < 300);
        chk("reach_g77", bus.D_Out, 78);
        chk("fo_busy", bus.Busy, 1);
        rst = 1'b1;
        tick;
        chk("midfade_rst_dout", bus.D_Out, 0);
        chk("midfade_rst_busy", bus.Busy, 0);
        rst = 1'b0;
        tick;
        tick;
        chk("no_resume_busy", bus.Busy, 0);
        chk("no_resume_dout", bus.D_Out, 0);

        // Fade_Len=3 up to G=10, reverse, back down to 0
        bus.Fade_Len = 8'd3;
        bus.Enable   = 1'b1;
        tick;
        chk("fl3_entry_dout", bus.D_Out, 0);
        chk("fl3_entry_busy", bus.Busy, 1);
        for (int m = 1; m <= 40; m++) begin
            tick;
            chk("fl3_up", bus.D_Out, (m - 1) / 4);
        end
        chk("fl3_up_busy", bus.Busy, 1);
        bus.Enable = 1'b0;
        tick;
        chk("fl3_rev_dout", bus.D_Out, 10);
        chk("fl3_rev_busy", bus.Busy, 1);
        for (int k = 1; k <= 40; k++) begin
            tick;
            chk("fl3_down", bus.D_Out, 10 - (k - 1) / 4);
            chk("fl3_down_busy", bus.Busy, (k < 40) ? 1 : 0);
        end
        tick;
        chk("fl3_final_dout", bus.D_Out, 0);

        // extreme-value sweep G=0..256 must be monotonic with no wrap
        bus.Fade_Len = 8'd0;
        bus.Dry_In   = 24'h800000;
        bus.Wet_In   = 24'h7FFFFF;
        bus.Enable   = 1'b1;
        tick;
        chk("sweep_start", bus.D_Out, 24'h800000);
        prev = bus.D_Out;
        for (int i = 1; i <= 257; i++) begin
            tick;
            cur = bus.D_Out;
            chk("sweep_mono", (cur >= prev) ? 1 : 0, 1);
            prev = cur;
        end
        chk("sweep_end", bus.D_Out, 24'h7FFFFF);
        chk("sweep_end_busy", bus.Busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bypass_fader.md
BYPASS_FADER -- requirements
Module: bypass_fader

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits (two's complement signed).
REQ-002 SHALL have port Lrck  input  1  sample-rate clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Enable  input  1  effect select: 1 = wet path, 0 = dry bypass.
REQ-005 SHALL have port Fade_Len  input  8  samples per gain step, minus one.
REQ-006 SHALL have port Dry_In  input  WIDTH  unprocessed sample, the same sample fed to the tremolo stage.
REQ-007 SHALL have port Wet_In  input  WIDTH  tremolo stage output sample.
REQ-008 SHALL have port D_Out  output  WIDTH  crossfaded sample, registered.
REQ-009 SHALL have port Busy  output  1  high while a fade is in progress.

Function
REQ-010 SHALL hold a 9-bit gain register G, range 0..256, and an 8-bit hold counter H.
REQ-011 SHALL implement the FSM states BYPASS (G=0), FADE_IN, ACTIVE (G=256) and FADE_OUT.
REQ-012 BYPASS with Enable=1 SHALL go to FADE_IN with H<=0 and G unchanged; BYPASS with Enable=0 SHALL stay in BYPASS.
REQ-013 ACTIVE with Enable=0 SHALL go to FADE_OUT with H<=0; ACTIVE with Enable=1 SHALL stay in ACTIVE.
REQ-014 In FADE_IN with Enable=1: if H>=Fade_Len then G<=G+1 and H<=0, else H<=H+1; on the edge where G becomes 256, state SHALL go to ACTIVE.
REQ-015 In FADE_OUT with Enable=0: if H>=Fade_Len then G<=G-1 and H<=0, else H<=H+1; on the edge where G becomes 0, state SHALL go to BYPASS.
REQ-016 Enable reversing mid-fade SHALL switch directly between FADE_IN and FADE_OUT with H<=0 and G unchanged, so the output never jumps.
REQ-017 Fade_Len SHALL be sampled live every edge; lowering it below H SHALL cause a step on the next edge (>= compare).
REQ-018 Full fade duration SHALL be 256*(Fade_Len+1) edges after the entry edge.
REQ-019 D_Out SHALL be registered as (Wet_In*G + Dry_In*(256-G)) >>> 8, using pre-edge G and inputs: one Lrck of latency.
REQ-020 The product and sum SHALL use signed arithmetic with WIDTH+10 bits, followed by an arithmetic shift; the result SHALL never exceed the WIDTH range.
REQ-021 Busy SHALL be decoded from the state register: 1 in FADE_IN and FADE_OUT, 0 otherwise.

Reset
REQ-022 Reset SHALL set state=BYPASS, G=0, H=0 and D_Out=0, so Busy=0.
REQ-023 Reset SHALL take priority over all transitions, including when asserted mid-fade; the fade SHALL be abandoned with no resume.
REQ-024 After reset deassertion with Enable=1, the block SHALL begin a FADE_IN on the first edge.

Configuration
REQ-025 With macro BYPASS_FADER_ROUND_EN defined, the block SHALL add 128 to the sum before the shift (round half up).
REQ-026 Without BYPASS_FADER_ROUND_EN, the block SHALL truncate toward negative infinity; port list and timing SHALL be identical in both builds.

Verification
REQ-027 Reset, Fade_Len=0, Enable=1 held -> Busy high for exactly 256 edges after the entry edge, then G=256, ACTIVE, D_Out tracks Wet_In with one-sample delay.
REQ-028 G=128, Dry_In=0x100000, Wet_In=0x300000 -> D_Out=0x200000 on the next edge.
REQ-029 G=128, Dry_In=0x000001, Wet_In=0 -> D_Out=0x000000 without the macro, 0x000001 with BYPASS_FADER_ROUND_EN.
REQ-030 Fade_Len=3, Enable 0->1, then dropped at G=10 -> G increments every 4 edges up to 10, then decrements from 10 every 4 edges to 0, BYPASS, Busy=0.
REQ-031 Reset pulsed mid-FADE_OUT at G=77 -> next edge D_Out=0, G=0, BYPASS, Busy=0.
REQ-032 Dry_In=0x800000, Wet_In=0x7FFFFF swept G=0..256 -> D_Out is monotonic from 0x800000 to 0x7FFFFF with no wrap.
